mem_port_arbiter: RTL and testbench

- Two-requester arbiter that shares one single-port synchronous data memory between the simple processor data port (requester 0) and a loader/debug master (requester 1).
- Serialises accesses with a req/gnt/rvalid handshake and round-robin priority.
- Returns read data to the winning requester only.
- Sits between the processor core and the data RAM in the processor-plus-memory subsystem.

---
 rtl/mem_port_arbiter.sv | 167 ++++++++++++++++
 tb/tb_mem_port_arbiter.sv | 398 +++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/mem_port_arbiter.sv
// Two-requester arbiter sharing one single-port synchronous data RAM between the
// processor data port (requester 0) and a loader/debug master (requester 1).

module mem_port_arbiter_lane #(
    parameter int width = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             cap,
    input  logic [width-1:0] mem_rdata,
    output logic [width-1:0] rdata
);

    // Holds the last read result for this requester until its next read completes.
    always_ff @(posedge clk) begin
        if (rst)
            rdata <= '0;
        else if (cap)
            rdata <= mem_rdata;
    end

endmodule

module mem_port_arbiter #(
    parameter int width    = 32,
    parameter int addrsize = 8,
    parameter bit RR_EN    = 1'b1
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                r0_req,
    input  logic                r0_we,
    input  logic [addrsize-1:0] r0_addr,
    input  logic [width-1:0]    r0_wdata,
    output logic                r0_gnt,
    output logic                r0_rvalid,
    output logic [width-1:0]    r0_rdata,
    input  logic                r1_req,
    input  logic                r1_we,
    input  logic [addrsize-1:0] r1_addr,
    input  logic [width-1:0]    r1_wdata,
    output logic                r1_gnt,
    output logic                r1_rvalid,
    output logic [width-1:0]    r1_rdata,
    output logic                mem_en,
    output logic                mem_we,
    output logic [addrsize-1:0] mem_addr,
    output logic [width-1:0]    mem_wdata,
    input  logic [width-1:0]    mem_rdata,
    output logic                busy,
    output logic                last_grant
);

    localparam int NUM_REQ = 2;

    typedef struct packed {
        logic                we;
        logic [addrsize-1:0] addr;
        logic [width-1:0]    wdata;
    } mem_req_t;

    typedef enum logic [1:0] {IDLE, ISSUE, WAIT, RESP} state_t;

    function automatic logic [NUM_REQ-1:0] to_onehot(input logic idx);
        logic [NUM_REQ-1:0] oh;
        oh      = '0;
        oh[idx] = 1'b1;
        return oh;
    endfunction

    logic     [NUM_REQ-1:0]            req;
    mem_req_t [NUM_REQ-1:0]            cmd;
    logic     [NUM_REQ-1:0][width-1:0] rdata;

    state_t               state;
    logic                 sel;
    logic                 last_q;
    logic                 pick;
    logic                 mem_en_q;
    mem_req_t             mem_q;
    logic [NUM_REQ-1:0]   gnt_q;
    logic [NUM_REQ-1:0]   cap_q;
    logic [NUM_REQ-1:0]   rv_q;

    assign req    = {r1_req, r0_req};
    assign cmd[0] = {r0_we, r0_addr, r0_wdata};
    assign cmd[1] = {r1_we, r1_addr, r1_wdata};

    // Contention goes to whoever did not win last time, or always to 0 in fixed mode.
    always_comb begin
        pick = 1'b0;
        if (req[0] && req[1])
            pick = RR_EN ? ~last_q : 1'b0;
        else
            pick = req[1];
    end

    // Pulse registers default low every cycle; each state raises only what it owns.
    always_ff @(posedge clk) begin
        if (rst) begin
            state    <= IDLE;
            sel      <= 1'b0;
            last_q   <= 1'b1;
            mem_en_q <= 1'b0;
            mem_q    <= '0;
            gnt_q    <= '0;
            cap_q    <= '0;
            rv_q     <= '0;
        end else begin
            mem_en_q <= 1'b0;
            mem_q    <= '0;
            gnt_q    <= '0;
            cap_q    <= '0;
            rv_q     <= '0;
            case (state)
                IDLE: begin
                    if (|req) begin
                        sel      <= pick;
                        last_q   <= pick;
                        gnt_q    <= to_onehot(pick);
                        mem_en_q <= 1'b1;
                        mem_q    <= cmd[pick];
                        state    <= ISSUE;
                    end
                end
                ISSUE: begin
                    if (mem_q.we) begin
                        state <= IDLE;
                    end else begin
                        cap_q <= to_onehot(sel);
                        state <= WAIT;
                    end
                end
                WAIT: begin
                    rv_q  <= to_onehot(sel);
                    state <= RESP;
                end
                RESP:    state <= IDLE;
                default: state <= IDLE;
            endcase
        end
    end

    for (genvar i = 0; i < NUM_REQ; i++) begin : g_lane
        mem_port_arbiter_lane #(.width(width)) u_lane (
            .clk       (clk),
            .rst       (rst),
            .cap       (cap_q[i]),
            .mem_rdata (mem_rdata),
            .rdata     (rdata[i])
        );
    end

    assign r0_gnt     = gnt_q[0];
    assign r1_gnt     = gnt_q[1];
    assign r0_rvalid  = rv_q[0];
    assign r1_rvalid  = rv_q[1];
    assign r0_rdata   = rdata[0];
    assign r1_rdata   = rdata[1];
    assign mem_en     = mem_en_q;
    assign mem_we     = mem_q.we;
    assign mem_addr   = mem_q.addr;
    assign mem_wdata  = mem_q.wdata;
    assign busy       = (state != IDLE);
    assign last_grant = last_q;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Bench for mem_port_arbiter: a round-robin and a fixed-priority instance share
// stimulus, each with its own behavioural RAM.

module tb_mem_port_arbiter;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    logic [1:0]  t_req = 2'b00;
    logic [1:0]  t_we  = 2'b00;
    logic [7:0]  t_addr [2];
    logic [31:0] t_wd   [2];

    wire  [1:0]  a_gnt, a_rv, b_gnt, b_rv;
    wire  [31:0] a_rd [2];
    wire  [31:0] b_rd [2];
    wire         a_en, a_we, b_en, b_we, a_busy, b_busy, a_last, b_last;
    wire  [7:0]  a_ad, b_ad;
    wire  [31:0] a_wd, b_wd;
    logic [31:0] a_mrd, b_mrd;

    logic        pre_en = 1'b0;
    logic [7:0]  pre_addr = 8'h0;
    logic [31:0] pre_data = 32'h0;
    logic [31:0] mem_a [256];
    logic [31:0] mem_b [256];
    logic [31:0] ref_mem [16];

    int n_chk  = 0;
    int n_fail = 0;

    mem_port_arbiter #(.width(32), .addrsize(8), .RR_EN(1'b1)) dut (
        .clk(clk), .rst(rst),
        .r0_req(t_req[0]), .r0_we(t_we[0]), .r0_addr(t_addr[0]), .r0_wdata(t_wd[0]),
        .r0_gnt(a_gnt[0]), .r0_rvalid(a_rv[0]), .r0_rdata(a_rd[0]),
        .r1_req(t_req[1]), .r1_we(t_we[1]), .r1_addr(t_addr[1]), .r1_wdata(t_wd[1]),
        .r1_gnt(a_gnt[1]), .r1_rvalid(a_rv[1]), .r1_rdata(a_rd[1]),
        .mem_en(a_en), .mem_we(a_we), .mem_addr(a_ad), .mem_wdata(a_wd),
        .mem_rdata(a_mrd), .busy(a_busy), .last_grant(a_last)
    );

    mem_port_arbiter #(.width(32), .addrsize(8), .RR_EN(1'b0)) dut_fp (
        .clk(clk), .rst(rst),
        .r0_req(t_req[0]), .r0_we(t_we[0]), .r0_addr(t_addr[0]), .r0_wdata(t_wd[0]),
        .r0_gnt(b_gnt[0]), .r0_rvalid(b_rv[0]), .r0_rdata(b_rd[0]),
        .r1_req(t_req[1]), .r1_we(t_we[1]), .r1_addr(t_addr[1]), .r1_wdata(t_wd[1]),
        .r1_gnt(b_gnt[1]), .r1_rvalid(b_rv[1]), .r1_rdata(b_rd[1]),
        .mem_en(b_en), .mem_we(b_we), .mem_addr(b_ad), .mem_wdata(b_wd),
        .mem_rdata(b_mrd), .busy(b_busy), .last_grant(b_last)
    );

    always @(posedge clk) begin
        if (pre_en) begin
            mem_a[pre_addr] <= pre_data;
            mem_b[pre_addr] <= pre_data;
        end
        if (a_en) begin
            if (a_we) mem_a[a_ad] <= a_wd;
            else      a_mrd <= mem_a[a_ad];
        end
        if (b_en) begin
            if (b_we) mem_b[b_ad] <= b_wd;
            else      b_mrd <= mem_b[b_ad];
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic preload(input logic [7:0] addr, input logic [31:0] data);
        pre_en = 1'b1; pre_addr = addr; pre_data = data;
        if (addr < 8'd16) ref_mem[addr[3:0]] = data;
        step();
        pre_en = 1'b0;
    endtask

    task automatic drain();
        for (int c = 0; c < 12 && (a_busy || b_busy); c++) step();
        n_chk++;
        if (a_busy || b_busy) begin
            n_fail++;
            $display("FAIL drain_timeout: busy a=%b b=%b, want 0", a_busy, b_busy);
        end
    endtask

    task automatic test_reset();
        rst = 1'b1; t_req = 2'b11; t_we = 2'b00; t_addr[0] = 8'h00; t_addr[1] = 8'h00;
        for (int c = 0; c < 2; c++) begin
            step();
            n_chk++;
            if ({a_gnt, a_rv, a_en, a_busy, b_gnt, b_rv, b_en, b_busy} !== 12'h0) begin
                n_fail++;
                $display("FAIL rst_ctrl: a gnt=%b rv=%b en=%b busy=%b b gnt=%b rv=%b en=%b busy=%b, want 0",
                         a_gnt, a_rv, a_en, a_busy, b_gnt, b_rv, b_en, b_busy);
            end
            n_chk++;
            if ({a_last, b_last} !== 2'b11) begin
                n_fail++;
                $display("FAIL rst_last_grant: got %b%b want 11", a_last, b_last);
            end
            n_chk++;
            if (a_rd[0] !== 32'h0 || a_rd[1] !== 32'h0 || a_we !== 1'b0 || a_ad !== 8'h0 || a_wd !== 32'h0) begin
                n_fail++;
                $display("FAIL rst_data: rd0=%h rd1=%h we=%b addr=%h wdata=%h, want 0",
                         a_rd[0], a_rd[1], a_we, a_ad, a_wd);
            end
        end
        rst = 1'b0;
        step();
        n_chk++;
        if (a_gnt !== 2'b01 || b_gnt !== 2'b01) begin
            n_fail++;
            $display("FAIL rst_first_grant: a=%b b=%b want 01", a_gnt, b_gnt);
        end
        t_req = 2'b00;
        drain();
    endtask

    task automatic test_write_read();
        t_req = 2'b01; t_we[0] = 1'b1; t_addr[0] = 8'h10; t_wd[0] = 32'hDEADBEEF;
        step();
        n_chk++;
        if (a_gnt !== 2'b01 || a_en !== 1'b1 || a_we !== 1'b1 || a_ad !== 8'h10 || a_wd !== 32'hDEADBEEF) begin
            n_fail++;
            $display("FAIL wr_issue: gnt=%b en=%b we=%b addr=%h wdata=%h, want 01 1 1 10 deadbeef",
                     a_gnt, a_en, a_we, a_ad, a_wd);
        end
        t_req = 2'b00;
        step();
        n_chk++;
        if (a_en !== 1'b0 || a_we !== 1'b0 || a_busy !== 1'b0) begin
            n_fail++;
            $display("FAIL wr_done: en=%b we=%b busy=%b, want 0 0 0", a_en, a_we, a_busy);
        end
        t_req = 2'b01; t_we[0] = 1'b0;
        step();
        n_chk++;
        if (a_gnt !== 2'b01 || a_en !== 1'b1 || a_we !== 1'b0 || a_ad !== 8'h10) begin
            n_fail++;
            $display("FAIL rd_issue: gnt=%b en=%b we=%b addr=%h, want 01 1 0 10", a_gnt, a_en, a_we, a_ad);
        end
        t_req = 2'b00;
        step();
        n_chk++;
        if (a_rv !== 2'b00 || a_en !== 1'b0 || a_busy !== 1'b1) begin
            n_fail++;
            $display("FAIL rd_wait: rv=%b en=%b busy=%b, want 00 0 1", a_rv, a_en, a_busy);
        end
        step();
        n_chk++;
        if (a_rv !== 2'b01 || a_rd[0] !== 32'hDEADBEEF || a_rd[1] !== 32'h0) begin
            n_fail++;
            $display("FAIL rd_resp: rv=%b rd0=%h rd1=%h, want 01 deadbeef 0", a_rv, a_rd[0], a_rd[1]);
        end
        step();
        n_chk++;
        if (a_rv !== 2'b00 || a_busy !== 1'b0) begin
            n_fail++;
            $display("FAIL rd_end: rv=%b busy=%b, want 00 0", a_rv, a_busy);
        end
    endtask

    task automatic test_contention();
        int  na = 0, nb = 0;
        bit  exp_w = 1'b1;   // r0 won the previous access
        bit  prev_en = 1'b0;
        preload(8'h01, 32'h11);
        preload(8'h02, 32'h22);
        t_req = 2'b11; t_we = 2'b00; t_addr[0] = 8'h01; t_addr[1] = 8'h02;
        for (int c = 0; c < 80 && na < 8; c++) begin
            step();
            if (|a_gnt) begin
                n_chk++;
                if (a_gnt !== (exp_w ? 2'b10 : 2'b01)) begin
                    n_fail++;
                    $display("FAIL rr_order: grant %0d got %b want index %0d", na, a_gnt, exp_w);
                end
                exp_w = ~exp_w;
                na++;
            end
            if (a_rv[0] || a_rv[1]) begin
                n_chk++;
                if ((a_rv == 2'b01 && a_rd[0] !== 32'h11) || (a_rv == 2'b10 && a_rd[1] !== 32'h22) || a_rv == 2'b11) begin
                    n_fail++;
                    $display("FAIL rr_data: rv=%b rd0=%h rd1=%h, want 11 on r0 or 22 on r1", a_rv, a_rd[0], a_rd[1]);
                end
            end
            n_chk++;
            if (a_en && prev_en) begin
                n_fail++;
                $display("FAIL rr_mem_en_b2b: en high two cycles, want a gap");
            end
            prev_en = a_en;
            n_chk++;
            if (b_gnt[1] !== 1'b0 || (b_rv[0] && b_rd[0] !== 32'h11)) begin
                n_fail++;
                $display("FAIL fp_r0_only: gnt=%b rv=%b rd0=%h, want r1 never granted, rd0=11", b_gnt, b_rv, b_rd[0]);
            end
            if (b_gnt[0]) nb++;
        end
        n_chk++;
        if (na != 8 || nb != 8) begin
            n_fail++;
            $display("FAIL contention_count: rr grants=%0d fp grants=%0d, want 8 8", na, nb);
        end
        t_req[0] = 1'b0;
        for (int c = 1; c <= 4; c++) begin
            step();
            n_chk++;
            if (b_gnt !== (c == 4 ? 2'b10 : 2'b00)) begin
                n_fail++;
                $display("FAIL fp_r1_after_drop: step %0d got %b want %b", c, b_gnt, (c == 4 ? 2'b10 : 2'b00));
            end
        end
        t_req = 2'b00;
        drain();
    endtask

    task automatic test_reset_mid_read();
        preload(8'h05, 32'h55555555);
        t_req = 2'b10; t_we[1] = 1'b0; t_addr[1] = 8'h05;
        step();
        n_chk++;
        if (a_gnt !== 2'b10) begin
            n_fail++;
            $display("FAIL midrst_gnt: got %b want 10", a_gnt);
        end
        t_req = 2'b00;
        step();
        rst = 1'b1;
        step();
        rst = 1'b0;
        n_chk++;
        if (a_rv !== 2'b00 || a_rd[1] !== 32'h0 || a_busy !== 1'b0 || a_last !== 1'b1) begin
            n_fail++;
            $display("FAIL midrst_discard: rv=%b rd1=%h busy=%b last=%b, want 00 0 0 1", a_rv, a_rd[1], a_busy, a_last);
        end
        step();
        n_chk++;
        if (a_rv !== 2'b00 || a_rd[1] !== 32'h0) begin
            n_fail++;
            $display("FAIL midrst_quiet: rv=%b rd1=%h, want 00 0", a_rv, a_rd[1]);
        end
        t_req = 2'b10;
        step();
        t_req = 2'b00;
        step();
        step();
        n_chk++;
        if (a_rv !== 2'b10 || a_rd[1] !== 32'h55555555) begin
            n_fail++;
            $display("FAIL midrst_retry: rv=%b rd1=%h, want 10 55555555", a_rv, a_rd[1]);
        end
        drain();
    endtask

    task automatic test_back_to_back();
        int  ng = 0;
        bit  got_rv = 1'b0;
        bit  prev_en = 1'b0;
        t_req = 2'b01; t_we[0] = 1'b1; t_addr[0] = 8'h7E; t_wd[0] = 32'h0;
        step();
        t_req = 2'b00;
        drain();
        t_req = 2'b11;
        t_we[1] = 1'b1; t_addr[1] = 8'h7F; t_wd[1] = 32'h12345678;
        t_we[0] = 1'b0; t_addr[0] = 8'h7F;
        for (int c = 0; c < 12; c++) begin
            step();
            if (|a_gnt) begin
                n_chk++;
                if (a_gnt !== (ng == 0 ? 2'b10 : 2'b01)) begin
                    n_fail++;
                    $display("FAIL b2b_order: grant %0d got %b want %b", ng, a_gnt, (ng == 0 ? 2'b10 : 2'b01));
                end
                t_req = t_req & ~a_gnt;
                ng++;
            end
            if (a_rv[0]) begin
                got_rv = 1'b1;
                n_chk++;
                if (a_rd[0] !== 32'h12345678) begin
                    n_fail++;
                    $display("FAIL b2b_rdata: got %h want 12345678", a_rd[0]);
                end
            end
            n_chk++;
            if ((a_en && prev_en) || (!a_en && a_we)) begin
                n_fail++;
                $display("FAIL b2b_mem_en: en=%b prev=%b we=%b, want no back-to-back strobe", a_en, prev_en, a_we);
            end
            prev_en = a_en;
        end
        n_chk++;
        if (!got_rv || ng != 2) begin
            n_fail++;
            $display("FAIL b2b_complete: grants=%0d rvalid_seen=%b, want 2 1", ng, got_rv);
        end
        t_req = 2'b00;
        drain();
    endtask

    // Transaction-level model: an access granted at edge k occupies the port
    // for 2 (write) or 4 (read) cycles; read data arrives 2 edges after grant.
    task automatic test_random();
        int          free_e = 0, busy_end = 0, rv_e = 0;
        bit          rv_pend = 1'b0, rv_who = 1'b0, m_last = 1'b1, w = 1'b0, prev_en = 1'b0;
        logic [31:0] m_rd [2];
        logic [31:0] rv_dat = 32'h0;
        logic [1:0]  e_gnt, e_rv, sq, swe;
        logic [7:0]  sad [2];
        logic [31:0] swd [2];
        bit          s_rst, e_busy;
        m_rd[0] = 32'h0; m_rd[1] = 32'h0;
        for (int i = 0; i < 16; i++) preload(8'(i), $urandom);
        rst = 1'b1;
        for (int i = 0; i < 600; i++) begin
            @(posedge clk);
            s_rst = rst; sq = t_req; swe = t_we;
            sad[0] = t_addr[0]; sad[1] = t_addr[1]; swd[0] = t_wd[0]; swd[1] = t_wd[1];
            #1;
            e_gnt = 2'b00; e_rv = 2'b00;
            if (s_rst) begin
                free_e = i + 1; busy_end = 0; rv_pend = 1'b0; m_last = 1'b1;
                m_rd[0] = 32'h0; m_rd[1] = 32'h0;
            end else begin
                if (rv_pend && rv_e == i) begin
                    e_rv[rv_who] = 1'b1; m_rd[rv_who] = rv_dat; rv_pend = 1'b0;
                end
                if (i >= free_e && sq != 2'b00) begin
                    w = (sq == 2'b11) ? ~m_last : sq[1];
                    e_gnt[w] = 1'b1; m_last = w;
                    if (swe[w]) begin
                        ref_mem[sad[w][3:0]] = swd[w];
                        free_e = i + 2;
                    end else begin
                        rv_pend = 1'b1; rv_e = i + 2; rv_who = w; rv_dat = ref_mem[sad[w][3:0]];
                        free_e = i + 4;
                    end
                    busy_end = free_e - 1;
                end
            end
            e_busy = (i < busy_end);
            n_chk++;
            if (a_gnt !== e_gnt || a_rv !== e_rv) begin
                n_fail++;
                $display("FAIL rnd_handshake: cycle %0d gnt=%b rv=%b, want %b %b", i, a_gnt, a_rv, e_gnt, e_rv);
            end
            n_chk++;
            if (a_rd[0] !== m_rd[0] || a_rd[1] !== m_rd[1]) begin
                n_fail++;
                $display("FAIL rnd_rdata: cycle %0d rd0=%h rd1=%h, want %h %h", i, a_rd[0], a_rd[1], m_rd[0], m_rd[1]);
            end
            n_chk++;
            if (a_en !== (|e_gnt) || a_busy !== e_busy || a_last !== m_last || (a_en && prev_en)) begin
                n_fail++;
                $display("FAIL rnd_ctrl: cycle %0d en=%b busy=%b last=%b, want %b %b %b",
                         i, a_en, a_busy, a_last, |e_gnt, e_busy, m_last);
            end
            prev_en = a_en;
            n_chk++;
            if ((|e_gnt) ? (a_we !== swe[w] || a_ad !== sad[w] || (swe[w] && a_wd !== swd[w])) : (a_we !== 1'b0)) begin
                n_fail++;
                $display("FAIL rnd_mem_cmd: cycle %0d we=%b addr=%h wdata=%h", i, a_we, a_ad, a_wd);
            end
            rst = ($urandom_range(0, 59) == 0);
            for (int n = 0; n < 2; n++) begin
                if (t_req[n] && a_gnt[n] && $urandom_range(0, 1) == 0) begin
                    t_req[n] = 1'b0;
                end else if ((t_req[n] && a_gnt[n]) || (!t_req[n] && $urandom_range(0, 2) == 0)) begin
                    t_req[n]  = 1'b1;
                    t_we[n]   = 1'($urandom_range(0, 1));
                    t_addr[n] = 8'($urandom_range(0, 15));
                    t_wd[n]   = $urandom;
                end
            end
        end
        rst = 1'b0; t_req = 2'b00;
        step();
        drain();
    endtask

    initial begin
        t_addr[0] = 8'h0; t_addr[1] = 8'h0; t_wd[0] = 32'h0; t_wd[1] = 32'h0;
        test_reset();
        test_write_read();
        test_contention();
        test_reset_mid_read();
        test_back_to_back();
        test_random();
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
